fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch/decode datapath: PC, MAR, MDR, CIR, AR and step counter, with ROM handshake,
// shared data-bus drive, conflict detection and a sticky halt.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] ctl,
    input  logic [7:0]  bus_in,
    output logic [7:0]  rom_addr,
    output logic        rom_req,
    input  logic [15:0] rom_rdata,
    input  logic        rom_ack,
    output logic [3:0]  step,
    output logic [7:0]  opcode,
    output logic [7:0]  operand,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    output logic        bus_conflict,
    output logic        halted
);

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_in;
        logic mar_in;
        logic mdr_in;
        logic cir_in;
        logic cir_out;
        logic ar_in;
        logic ar_out;
        logic sc_inc;
        logic sc_reset;
        logic halt;
    } ctl_t;

    ctl_t c;
    assign c = ctl_t'(ctl);

    logic [7:0]  pc_q,  pc_d;
    logic [7:0]  mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [15:0] cir_q, cir_d;
    logic [7:0]  ar_q,  ar_d;
    logic [3:0]  sc_q,  sc_d;
    logic        halted_q, halted_d;
    logic        conflict_q, conflict_d;
    logic        stall;
    logic        drive_ok;

    assign stall = c.mdr_in & ~rom_ack;

    // NOTE: every signal written here gets its default first, so no path leaves it unassigned (no latches).
    always_comb begin
        pc_d       = pc_q;
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        cir_d      = cir_q;
        ar_d       = ar_q;
        sc_d       = sc_q;
        halted_d   = halted_q;
        conflict_d = 1'b0;

        if (!halted_q) begin
            if (c.pc_in)
                pc_d = bus_in;
            else if (c.pc_inc)
                pc_d = pc_q + 8'd1;

            if (c.mar_in)
                mar_d = c.pc_out ? pc_q : bus_in;

            if (c.mdr_in && rom_ack)
                mdr_d = rom_rdata;

            if (c.cir_in)
                cir_d = mdr_q;

            if (c.ar_in)
                ar_d = c.cir_out ? cir_q[7:0] : bus_in;

            // A stall holds only the step counter; the other strobes still act.
            if (c.sc_reset)
                sc_d = 4'd0;
            else if (!stall && c.sc_inc)
                sc_d = sc_q + 4'd1;

            halted_d   = c.halt;
            conflict_d = c.pc_out & c.ar_out;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            cir_q      <= '0;
            ar_q       <= '0;
            sc_q       <= '0;
            halted_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            cir_q      <= cir_d;
            ar_q       <= ar_d;
            sc_q       <= sc_d;
            halted_q   <= halted_d;
            conflict_q <= conflict_d;
        end
    end

    // Nothing is requested or driven while halted or held in reset.
    assign drive_ok = rst_n & ~halted_q;

    always_comb begin
        bus_out = 8'h00;
        bus_oe  = 1'b0;
        if (drive_ok) begin
            if (c.pc_out) begin
                bus_out = pc_q;
                bus_oe  = 1'b1;
            end else if (c.ar_out) begin
                bus_out = ar_q;
                bus_oe  = 1'b1;
            end
        end
    end

    assign rom_req      = c.mdr_in & drive_ok;
    assign rom_addr     = mar_q;
    assign step         = sc_q;
    assign opcode       = cir_q[15:8];
    assign operand      = ar_q;
    assign bus_conflict = conflict_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_unit;

    localparam logic [11:0] PC_OUT  = 12'h800;
    localparam logic [11:0] PC_INC  = 12'h400;
    localparam logic [11:0] PC_IN   = 12'h200;
    localparam logic [11:0] MAR_IN  = 12'h100;
    localparam logic [11:0] MDR_IN  = 12'h080;
    localparam logic [11:0] CIR_IN  = 12'h040;
    localparam logic [11:0] CIR_OUT = 12'h020;
    localparam logic [11:0] AR_IN   = 12'h010;
    localparam logic [11:0] AR_OUT  = 12'h008;
    localparam logic [11:0] SC_INC  = 12'h004;
    localparam logic [11:0] SC_RST  = 12'h002;
    localparam logic [11:0] HALT    = 12'h001;

    typedef enum logic [3:0] {
        S_STEP, S_OPCODE, S_OPERAND, S_ROM_ADDR, S_ROM_REQ,
        S_BUS_OUT, S_BUS_OE, S_CONFLICT, S_HALTED
    } sig_e;

    typedef struct {
        sig_e        sig;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] ctl;
    logic [7:0]  bus_in;
    logic [7:0]  rom_addr;
    logic        rom_req;
    logic [15:0] rom_rdata;
    logic        rom_ack;
    logic [3:0]  step;
    logic [7:0]  opcode;
    logic [7:0]  operand;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic        bus_conflict;
    logic        halted;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctl          (ctl),
        .bus_in       (bus_in),
        .rom_addr     (rom_addr),
        .rom_req      (rom_req),
        .rom_rdata    (rom_rdata),
        .rom_ack      (rom_ack),
        .step         (step),
        .opcode       (opcode),
        .operand      (operand),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .bus_conflict (bus_conflict),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sample(input sig_e s);
        case (s)
            S_STEP:     return {12'h000, step};
            S_OPCODE:   return {8'h00, opcode};
            S_OPERAND:  return {8'h00, operand};
            S_ROM_ADDR: return {8'h00, rom_addr};
            S_ROM_REQ:  return {15'h0000, rom_req};
            S_BUS_OUT:  return {8'h00, bus_out};
            S_BUS_OE:   return {15'h0000, bus_oe};
            S_CONFLICT: return {15'h0000, bus_conflict};
            default:    return {15'h0000, halted};
        endcase
    endfunction

    task automatic check(input exp_t e);
        logic [15:0] act;
        act = sample(e.sig);
        n_tests++;
        if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", e.name, act, e.val, $time);
        end
    endtask

    // Monitor: outputs are settled at the falling edge, half a cycle from the active edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) check(exp_q.pop_front());
    end

    task automatic expect_sig(input sig_e s, input logic [15:0] v, input string n);
        exp_t e;
        e.sig  = s;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [11:0] c, input logic [7:0] b,
                         input logic a, input logic [15:0] d);
        ctl       = c;
        bus_in    = b;
        rom_ack   = a;
        rom_rdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Five-step fetch from address PC=0 with rom_ack held high.
    task automatic fetch(input logic [15:0] w);
        logic [7:0] op_hi;
        logic [7:0] op_lo;
        op_hi = w[15:8];
        op_lo = w[7:0];
        drive(PC_OUT | MAR_IN | SC_INC, 8'h00, 1'b1, w);
        expect_sig(S_STEP, 16'd0, "fetch_step0");
        expect_sig(S_BUS_OUT, 16'h00, "fetch_pc_on_bus");
        expect_sig(S_BUS_OE, 16'd1, "fetch_bus_oe");
        tick();
        drive(MDR_IN | PC_INC | SC_INC, 8'h00, 1'b1, w);
        expect_sig(S_STEP, 16'd1, "fetch_step1");
        expect_sig(S_ROM_REQ, 16'd1, "fetch_rom_req");
        expect_sig(S_ROM_ADDR, 16'h00, "fetch_rom_addr");
        tick();
        drive(CIR_IN | SC_INC, 8'h00, 1'b1, w);
        expect_sig(S_STEP, 16'd2, "fetch_step2");
        tick();
        drive(CIR_OUT | AR_IN | SC_INC, 8'hEE, 1'b1, w);
        expect_sig(S_STEP, 16'd3, "fetch_step3");
        expect_sig(S_OPCODE, {8'h00, op_hi}, "fetch_opcode");
        tick();
        drive(SC_INC, 8'h00, 1'b1, w);
        expect_sig(S_STEP, 16'd4, "fetch_step4");
        expect_sig(S_OPERAND, {8'h00, op_lo}, "fetch_operand");
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(12'h000, 8'h00, 1'b0, 16'h0000);
        tick();

        // Reset state; rom_req stays low even with MDR_in asserted.
        drive(MDR_IN, 8'h00, 1'b1, 16'h1305);
        expect_sig(S_STEP, 16'd0, "rst_step");
        expect_sig(S_OPCODE, 16'd0, "rst_opcode");
        expect_sig(S_OPERAND, 16'd0, "rst_operand");
        expect_sig(S_ROM_ADDR, 16'd0, "rst_rom_addr");
        expect_sig(S_ROM_REQ, 16'd0, "rst_rom_req");
        expect_sig(S_HALTED, 16'd0, "rst_halted");
        expect_sig(S_CONFLICT, 16'd0, "rst_conflict");
        tick();
        rst_n = 1'b1;

        // Fetch of 0x1305 -> step 5, PC 1.
        fetch(16'h1305);
        drive(PC_OUT, 8'h00, 1'b1, 16'h1305);
        expect_sig(S_STEP, 16'd5, "fetch_step5");
        expect_sig(S_BUS_OUT, 16'h01, "fetch_pc_after");
        expect_sig(S_OPCODE, 16'h13, "fetch_opcode_hold");
        expect_sig(S_OPERAND, 16'h05, "fetch_operand_hold");
        tick();

        // Stall: three cycles without ack at step 1, AR load still acts mid-stall.
        drive(SC_RST, 8'h00, 1'b0, 16'h0000);
        tick();
        drive(PC_OUT | MAR_IN | SC_INC, 8'h00, 1'b1, 16'h0000);
        expect_sig(S_STEP, 16'd0, "stall_step0");
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(MDR_IN | SC_INC | ((i == 1) ? AR_IN : 12'h000), 8'h5A, 1'b0, 16'hDEAD);
            expect_sig(S_STEP, 16'd1, "stall_step_hold");
            expect_sig(S_ROM_REQ, 16'd1, "stall_rom_req");
            expect_sig(S_ROM_ADDR, 16'h01, "stall_rom_addr");
            tick();
        end
        drive(MDR_IN | PC_INC | SC_INC, 8'h00, 1'b1, 16'hA7C2);
        expect_sig(S_STEP, 16'd1, "stall_ack_step");
        expect_sig(S_ROM_REQ, 16'd1, "stall_ack_req");
        expect_sig(S_OPERAND, 16'h5A, "stall_ar_loaded");
        tick();
        drive(CIR_IN | SC_INC, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_STEP, 16'd2, "stall_step2");
        tick();
        drive(PC_OUT, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_STEP, 16'd3, "stall_step3");
        expect_sig(S_OPCODE, 16'hA7, "stall_mdr_loaded");
        expect_sig(S_BUS_OUT, 16'h02, "stall_pc");
        tick();

        // Jump, PC wrap and SC reset-over-increment.
        drive(PC_IN | SC_INC, 8'hFF, 1'b0, 16'h0000);
        expect_sig(S_STEP, 16'd3, "jump_step3");
        tick();
        drive(PC_OUT | PC_INC | SC_INC, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_BUS_OUT, 16'hFF, "jump_pc_ff");
        tick();
        drive(PC_OUT | PC_IN | PC_INC | SC_INC, 8'h40, 1'b0, 16'h0000);
        expect_sig(S_BUS_OUT, 16'h00, "jump_pc_wrap");
        tick();
        drive(PC_OUT | SC_INC, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_BUS_OUT, 16'h40, "jump_pc_in_wins");
        expect_sig(S_STEP, 16'd6, "jump_step6");
        tick();
        drive(SC_RST | SC_INC, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_STEP, 16'd7, "sc_step7");
        tick();
        drive(12'h000, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_STEP, 16'd0, "sc_reset_wins");
        tick();

        // Bus conflict.
        drive(PC_IN, 8'h22, 1'b0, 16'h0000);
        tick();
        drive(AR_IN, 8'h33, 1'b0, 16'h0000);
        tick();
        drive(PC_OUT | AR_OUT, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_BUS_OUT, 16'h22, "conf_bus_pc");
        expect_sig(S_BUS_OE, 16'd1, "conf_bus_oe");
        expect_sig(S_CONFLICT, 16'd0, "conf_not_yet");
        tick();
        drive(AR_OUT, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_CONFLICT, 16'd1, "conf_pulse");
        expect_sig(S_BUS_OUT, 16'h33, "conf_bus_ar");
        tick();
        drive(12'h000, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_CONFLICT, 16'd0, "conf_one_cycle");
        expect_sig(S_BUS_OE, 16'd0, "conf_idle_oe");
        expect_sig(S_BUS_OUT, 16'h00, "conf_idle_bus");
        tick();

        // Asynchronous reset between edges at step 3.
        for (int i = 0; i < 3; i++) begin
            drive(SC_INC, 8'h00, 1'b0, 16'h0000);
            expect_sig(S_STEP, 16'(i), "areset_ramp");
            tick();
        end
        drive(12'h000, 8'h00, 1'b0, 16'h0000);
        rst_n = 1'b0;
        expect_sig(S_STEP, 16'd0, "areset_step");
        expect_sig(S_OPCODE, 16'd0, "areset_opcode");
        expect_sig(S_OPERAND, 16'd0, "areset_operand");
        expect_sig(S_ROM_ADDR, 16'd0, "areset_rom_addr");
        tick();
        rst_n = 1'b1;
        drive(SC_INC, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_STEP, 16'd0, "post_rst_step0");
        tick();
        drive(12'h000, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_STEP, 16'd1, "post_rst_step1");
        tick();

        // Halt at step 5 with a same-edge AR load, then freeze for 10 cycles.
        drive(SC_RST, 8'h00, 1'b0, 16'h0000);
        tick();
        fetch(16'h2A11);
        drive(HALT | AR_IN, 8'h99, 1'b1, 16'h0000);
        expect_sig(S_STEP, 16'd5, "halt_step5");
        expect_sig(S_HALTED, 16'd0, "halt_not_yet");
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(SC_INC | PC_INC | MDR_IN | PC_OUT | MAR_IN | CIR_IN | AR_IN | HALT,
                  8'h77, 1'b1, 16'hFFFF);
            expect_sig(S_HALTED, 16'd1, "halt_sticky");
            expect_sig(S_STEP, 16'd5, "halt_step_frozen");
            expect_sig(S_ROM_REQ, 16'd0, "halt_rom_req");
            expect_sig(S_BUS_OE, 16'd0, "halt_bus_oe");
            expect_sig(S_OPCODE, 16'h2A, "halt_opcode_frozen");
            expect_sig(S_OPERAND, 16'h99, "halt_operand_frozen");
            expect_sig(S_ROM_ADDR, 16'h00, "halt_mar_frozen");
            tick();
        end
        rst_n = 1'b0;
        expect_sig(S_STEP, 16'd0, "hrst_step");
        expect_sig(S_OPCODE, 16'd0, "hrst_opcode");
        expect_sig(S_OPERAND, 16'd0, "hrst_operand");
        expect_sig(S_ROM_ADDR, 16'd0, "hrst_rom_addr");
        expect_sig(S_ROM_REQ, 16'd0, "hrst_rom_req");
        expect_sig(S_BUS_OUT, 16'd0, "hrst_bus_out");
        expect_sig(S_BUS_OE, 16'd0, "hrst_bus_oe");
        expect_sig(S_CONFLICT, 16'd0, "hrst_conflict");
        expect_sig(S_HALTED, 16'd0, "hrst_halted");
        tick();
        rst_n = 1'b1;
        drive(MDR_IN | SC_INC, 8'h00, 1'b1, 16'h0000);
        expect_sig(S_HALTED, 16'd0, "unhalt_halted");
        expect_sig(S_ROM_REQ, 16'd1, "unhalt_rom_req");
        expect_sig(S_STEP, 16'd0, "unhalt_step0");
        tick();
        drive(12'h000, 8'h00, 1'b0, 16'h0000);
        expect_sig(S_STEP, 16'd1, "unhalt_step1");
        tick();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
